// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the registered round-robin / fixed-priority
// arbiter and its combinational picker.
package rr_arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int MAX_PORTS = 32;

    // Index width for n requesters; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Index of the set bit of a one-hot vector; 0 for an all-zero vector.
    function automatic logic [4:0] onehot2idx(input logic [MAX_PORTS-1:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (oh[i]) idx = idx | 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational masked priority picker: first candidate at or above ptr,
// wrapping to the lowest candidate. Bits set in excl never win.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter  int PORTS = 4,
    localparam int IDX_W = idx_width(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic [PORTS-1:0] excl,
    output logic [PORTS-1:0] win,
    output logic             any
);

    logic [PORTS-1:0] cand;
    logic [PORTS-1:0] upper;
    logic [PORTS-1:0] upper_win;
    logic [PORTS-1:0] all_win;

    // Masked (>= ptr) and unmasked lowest-set-bit pickers; masked wins if non-empty.
    always_comb begin
        cand      = req & ~excl;
        upper     = cand & ({PORTS{1'b1}} << ptr);
        upper_win = upper & (~upper + PORTS'(1));
        all_win   = cand & (~cand + PORTS'(1));
        win       = (|upper) ? upper_win : all_win;
        any       = |cand;
    end

endmodule

// File: rtl/rr_priority_arbiter.sv
// Registered arbiter for PORTS requesters with runtime fixed-priority /
// round-robin policy, grant lock and an optional hold-cycle limit.
// Optional per-port new-grant counters are built when ARB_GRANT_CNT_EN is defined.
module rr_priority_arbiter
    import rr_arb_pkg::*;
#(
    parameter int PORTS    = 4,
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PORTS-1:0]          req,
    input  logic                      mode,
    output logic [PORTS-1:0]          gnt,
    output logic                      gnt_valid,
    output logic [$clog2(PORTS)-1:0]  gnt_id
`ifdef ARB_GRANT_CNT_EN
    ,
    output logic [PORTS*CNT_W-1:0]    gnt_cnt
`endif
);

    localparam int IDX_W  = idx_width(PORTS);
    localparam int HCNT_W = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [HCNT_W-1:0] HOLD_LIM = HCNT_W'(HOLD_MAX);

    arb_state_e        state_q, state_d;
    logic [PORTS-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]  id_q, id_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;

    logic              held;
    logic              limit_hit;
    logic [PORTS-1:0]  pick_excl;
    logic [IDX_W-1:0]  pick_ptr;
    logic [PORTS-1:0]  pick_win;
    logic              pick_any;
    logic              new_grant;
    logic [PORTS-1:0]  win_sel;
    logic [IDX_W-1:0]  win_idx;

    // Holder status and picker controls; the holder is excluded only on a forced re-arbitration.
    always_comb begin
        held      = |(req & gnt_q);
        limit_hit = (HOLD_MAX != 0) && (hcnt_q == HOLD_LIM);
        pick_excl = (state_q == ARB_GRANT && held && limit_hit) ? gnt_q : '0;
        pick_ptr  = (arb_mode_e'(mode) == ARB_RR) ? ptr_q : '0;
    end

    rr_pick #(.PORTS(PORTS)) u_pick (
        .req  (req),
        .ptr  (pick_ptr),
        .excl (pick_excl),
        .win  (pick_win),
        .any  (pick_any)
    );

    // Next-state, grant, hold counter and pointer update.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        hcnt_d    = hcnt_q;
        ptr_d     = ptr_q;
        new_grant = 1'b0;
        win_sel   = '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    new_grant = 1'b1;
                    win_sel   = pick_win;
                end
            end
            ARB_GRANT: begin
                if (held && !limit_hit) begin
                    // Lock held; counter only advances when a limit exists.
                    if (HOLD_MAX != 0) hcnt_d = hcnt_q + HCNT_W'(1);
                end else if (pick_any) begin
                    new_grant = 1'b1;
                    win_sel   = pick_win;
                end else if (held) begin
                    // Holder hit its limit but nobody else wants the resource.
                    new_grant = 1'b1;
                    win_sel   = gnt_q;
                end else begin
                    state_d = ARB_IDLE;
                    gnt_d   = '0;
                    hcnt_d  = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
                hcnt_d  = '0;
            end
        endcase

        win_idx = IDX_W'(onehot2idx(MAX_PORTS'(win_sel)));
        if (new_grant) begin
            state_d = ARB_GRANT;
            gnt_d   = win_sel;
            hcnt_d  = HCNT_W'(1);
            ptr_d   = (win_idx == IDX_W'(PORTS - 1)) ? '0 : win_idx + IDX_W'(1);
        end
        id_d = IDX_W'(onehot2idx(MAX_PORTS'(gnt_d)));
    end

    // Arbiter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            hcnt_q  <= hcnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_id    = id_q;

`ifdef ARB_GRANT_CNT_EN
    for (genvar i = 0; i < PORTS; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q, cnt_d;

        // Count new grants to this port, saturating at all-ones.
        always_comb begin
            cnt_d = cnt_q;
            if (new_grant && win_sel[i] && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
        end

        // Counter register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) cnt_q <= '0;
            else     cnt_q <= cnt_d;
        end

        assign gnt_cnt[i*CNT_W +: CNT_W] = cnt_q;
    end
`endif

endmodule
